// File: rtl/alu_op44.sv
// alu_op44: 8-bit, 8-function ALU with carry-in/carry-out and a registered output stage.
// The combinational result {c, r} is selected by op_sel and captured on every rising clk edge.
module alu_op44 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Ain,
  input  logic [7:0] Bin,
  input  logic       Carryin,
  input  logic [2:0] op_sel,
  output logic       Carryout,
  output logic [7:0] alu_out
);

  typedef enum logic [2:0] {
    OP_ADC = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  op_e        op;
  logic [7:0] alu_out_d, alu_out_q;
  logic       carry_d,   carry_q;
  logic [8:0] sum;
  logic [8:0] diff;

  assign op = op_e'(op_sel);

  // The borrow of an unsigned subtract is bit 8 of the 9-bit difference.
  assign sum  = {1'b0, Ain} + {1'b0, Bin} + {8'd0, Carryin};
  assign diff = {1'b0, Ain} - {1'b0, Bin};

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    alu_out_d = 8'h00;
    carry_d   = 1'b0;
    unique case (op)
      OP_ADC: {carry_d, alu_out_d} = sum;
      OP_SUB: {carry_d, alu_out_d} = diff;
      OP_AND: alu_out_d = Ain & Bin;
      OP_OR:  alu_out_d = Ain | Bin;
      OP_XOR: alu_out_d = Ain ^ Bin;
      OP_NOT: alu_out_d = ~Ain;
      OP_SHL: {carry_d, alu_out_d} = {Ain, Carryin};
      OP_SHR: {alu_out_d, carry_d} = {Carryin, Ain};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= 8'h00;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
    end
  end

  assign alu_out  = alu_out_q;
  assign Carryout = carry_q;

endmodule

// File: tb/tb_alu_op44.sv
// tb_alu_op44: directed-vector self-checking bench for alu_op44.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_alu_op44;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [7:0] Ain;
  logic [7:0] Bin;
  logic       Carryin;
  logic [2:0] op_sel;
  logic       Carryout;
  logic [7:0] alu_out;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;   // {Carryout, alu_out}
    string      tag;
  } vec_t;

  alu_op44 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Ain      (Ain),
    .Bin      (Bin),
    .Carryin  (Carryin),
    .op_sel   (op_sel),
    .Carryout (Carryout),
    .alu_out  (alu_out)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got c=%b out=%h, required c=%b out=%h",
               tag, got[8], got[7:0], exp[8], exp[7:0]);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    op_sel  = op;
    Ain     = a;
    Bin     = b;
    Carryin = cin;
  endtask

  // Drive on the falling edge, then check the value captured by the next rising edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.op, v.a, v.b, v.cin);
    @(posedge clk);
    #1;
    check(v.tag, {Carryout, alu_out}, v.exp);
  endtask

  vec_t vecs[$];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    drive(3'd0, 8'hA7, 8'h3C, 1'b1);

    // Async reset with the clock stopped.
    #3 rst_n = 1'b0;
    #1 check("reset_async", {Carryout, alu_out}, 9'h000);

    // Pending inputs held across an edge during reset are not captured.
    clk_en = 1'b1;
    drive(3'd0, 8'hCC, 8'h55, 1'b1);
    @(posedge clk);
    #1 check("reset_hold_edge", {Carryout, alu_out}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_no_edge", {Carryout, alu_out}, 9'h000);
    @(posedge clk);
    #1 check("first_edge_adc", {Carryout, alu_out}, {1'b1, 8'h22});

    // op_sel sweep with CC/55/1, one op per clock.
    vecs = '{
      '{3'd0, 8'hCC, 8'h55, 1'b1, {1'b1, 8'h22}, "sweep_adc"},
      '{3'd1, 8'hCC, 8'h55, 1'b1, {1'b0, 8'h77}, "sweep_sub"},
      '{3'd2, 8'hCC, 8'h55, 1'b1, {1'b0, 8'h44}, "sweep_and"},
      '{3'd3, 8'hCC, 8'h55, 1'b1, {1'b0, 8'hDD}, "sweep_or"},
      '{3'd4, 8'hCC, 8'h55, 1'b1, {1'b0, 8'h99}, "sweep_xor"},
      '{3'd5, 8'hCC, 8'h55, 1'b1, {1'b0, 8'h33}, "sweep_not"},
      '{3'd6, 8'hCC, 8'h55, 1'b1, {1'b1, 8'h99}, "sweep_shl"},
      '{3'd7, 8'hCC, 8'h55, 1'b1, {1'b0, 8'hE6}, "sweep_shr"},
      '{3'd1, 8'h08, 8'h06, 1'b1, {1'b0, 8'h02}, "small_sub"},
      '{3'd2, 8'h08, 8'h06, 1'b1, {1'b0, 8'h00}, "small_and"},
      '{3'd3, 8'h08, 8'h06, 1'b1, {1'b0, 8'h0E}, "small_or"},
      '{3'd0, 8'hFF, 8'h01, 1'b0, {1'b1, 8'h00}, "adc_wrap"},
      '{3'd0, 8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF}, "adc_max"},
      '{3'd1, 8'h00, 8'h01, 1'b1, {1'b1, 8'hFF}, "sub_borrow"},
      '{3'd1, 8'h5A, 8'h5A, 1'b0, {1'b0, 8'h00}, "sub_equal"},
      '{3'd6, 8'h81, 8'h00, 1'b0, {1'b1, 8'h02}, "shl_81"},
      '{3'd7, 8'h81, 8'h00, 1'b0, {1'b1, 8'h40}, "shr_81"},
      '{3'd5, 8'h0F, 8'hAA, 1'b1, {1'b0, 8'hF0}, "not_ignores_b"}
    };
    foreach (vecs[i]) run_vec(vecs[i]);

    // Mid-cycle input change has no effect until the next rising edge.
    run_vec('{3'd0, 8'h01, 8'h01, 1'b0, {1'b0, 8'h02}, "hold_load"});
    @(negedge clk);
    drive(3'd4, 8'hFF, 8'h0F, 1'b0);
    #1 check("hold_mid_cycle", {Carryout, alu_out}, {1'b0, 8'h02});
    @(posedge clk);
    #1 check("hold_next_edge", {Carryout, alu_out}, {1'b0, 8'hF0});

    // Reset asserted mid-stream clears at once and blocks the pending capture.
    @(negedge clk);
    drive(3'd0, 8'h80, 8'h80, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("midstream_reset", {Carryout, alu_out}, 9'h000);
    @(posedge clk);
    #1 check("midstream_reset_edge", {Carryout, alu_out}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_release", {Carryout, alu_out}, {1'b1, 8'h01});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
